// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write bus of the loader
interface imem_loader_if #(
    parameter int ADDR_W = 32
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    modport master (input rx_valid, rx_data, output rx_ready, mem_we, mem_addr, mem_wdata);
    modport slave  (output rx_valid, rx_data, input rx_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader turning a length-prefixed little-endian byte stream into instruction-memory word writes
module imem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    imem_loader_if.master  bus,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic [15:0]    words_loaded
);
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR} state_t;
    state_t      state;
    logic [15:0] len;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] wbuf;
    logic        acc;
    logic [15:0] len_n;
    assign acc   = bus.rx_valid && bus.rx_ready;
    assign len_n = {bus.rx_data, len[7:0]};
    // rx_ready, mem_we and busy are set on the transition into the state they decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            len           <= '0;
            word_idx      <= '0;
            byte_idx      <= '0;
            wbuf          <= '0;
            bus.rx_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            words_loaded  <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: if (start) begin
                    state        <= LEN0;
                    bus.rx_ready <= 1'b1;
                    busy         <= 1'b1;
                    done         <= 1'b0;
                    error        <= 1'b0;
                    words_loaded <= '0;
                end
                LEN0: if (acc) begin
                    len[7:0] <= bus.rx_data;
                    state    <= LEN1;
                end
                LEN1: if (acc) begin
                    len      <= len_n;
                    byte_idx <= '0;
                    word_idx <= '0;
                    if (len_n == 16'd0) begin
                        state        <= DONE;
                        bus.rx_ready <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                    end else if ({16'd0, len_n} > 32'(DEPTH)) begin
                        state        <= ERR;
                        bus.rx_ready <= 1'b0;
                        busy         <= 1'b0;
                        error        <= 1'b1;
                    end else begin
                        state <= DATA;
                    end
                end
                DATA: if (acc) begin
                    // bytes shift in from the top so the first byte ends up least significant
                    wbuf     <= {bus.rx_data, wbuf[23:8]};
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        state         <= WRITE;
                        bus.rx_ready  <= 1'b0;
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= ADDR_W'({word_idx, 2'b00});
                        bus.mem_wdata <= {bus.rx_data, wbuf};
                    end
                end
                WRITE: begin
                    word_idx     <= word_idx + 16'd1;
                    words_loaded <= word_idx + 16'd1;
                    if (word_idx + 16'd1 == len) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state        <= DATA;
                        bus.rx_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized and directed frames checked every cycle against a byte-count model of the loader
module tb_imem_loader;
    localparam int DEPTH = 256;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, error;
    logic [15:0] words_loaded;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(32)) bus();
    imem_loader #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
        .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: frame progress tracked as bytes accepted and words written
    logic        m_busy, m_done, m_err, m_we;
    logic [31:0] m_addr, m_data, m_word;
    int          m_wl, m_n, m_len;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_err = 0; m_we = 0;
            m_addr = 0; m_data = 0; m_word = 0;
            m_wl = 0; m_n = 0; m_len = 0;
        end else if (m_we) begin
            m_we = 0;
            m_wl++;
            if (m_wl == m_len) begin m_busy = 0; m_done = 1; end
        end else if (!m_busy) begin
            if (start) begin m_busy = 1; m_done = 0; m_err = 0; m_wl = 0; m_n = 0; end
        end else if (bus.rx_valid) begin
            if (m_n == 0) m_len = int'(bus.rx_data);
            else if (m_n == 1) begin
                m_len += 256 * int'(bus.rx_data);
                if (m_len == 0) begin m_busy = 0; m_done = 1; end
                else if (m_len > DEPTH) begin m_busy = 0; m_err = 1; end
            end else begin
                m_word[8*((m_n-2)%4) +: 8] = bus.rx_data;
                if ((m_n - 2) % 4 == 3) begin
                    m_we = 1; m_addr = 32'(((m_n - 2) / 4) * 4); m_data = m_word;
                end
            end
            m_n++;
        end
    end

    always @(negedge clk) begin
        chk("rx_ready", 32'(bus.rx_ready), 32'(m_busy && !m_we));
        chk("mem_we", 32'(bus.mem_we), 32'(m_we));
        chk("mem_addr", bus.mem_addr, m_addr);
        chk("mem_wdata", bus.mem_wdata, m_data);
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("error", 32'(error), 32'(m_err));
        chk("words_loaded", 32'(words_loaded), 32'(m_wl));
        if (bus.mem_we) begin wr_addr.push_back(bus.mem_addr); wr_data.push_back(bus.mem_wdata); end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got = 0;
        repeat (gap) @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int t = 0; t < 100 && !got; t++) begin
            got = bus.rx_ready;
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
        checks++;
        if (!got) begin errors++; $display("FAIL rx_accept byte %h not accepted within 100 cycles", b); end
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 5000 && busy; t++) @(negedge clk);
        chk("frame_end", 32'(busy), 32'd0);
    endtask

    task automatic frame_a(input int maxgap, input bit poke);
        logic [7:0] fa [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            if (poke && i == 5) pulse_start();
            send_byte(fa[i], $urandom_range(0, maxgap));
        end
        wait_idle();
        chk("a_nwrites", wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            chk("a_addr0", wr_addr[0], 32'h0);
            chk("a_data0", wr_data[0], 32'h00A00513);
            chk("a_addr1", wr_addr[1], 32'h4);
            chk("a_data1", wr_data[1], 32'h00100593);
        end
        chk("a_done", 32'(done), 1);
        chk("a_error", 32'(error), 0);
        chk("a_words", 32'(words_loaded), 2);
    endtask

    task automatic send_frame(input int len, input int gap, input bit poke);
        bit ok = len > 0 && len <= DEPTH;
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        send_byte(len[7:0], gap);
        send_byte(len[15:8], gap);
        if (ok) for (int i = 0; i < len * 4; i++) begin
            if (poke && i == 5) pulse_start();
            send_byte(8'($urandom), $urandom_range(0, gap));
        end
        wait_idle();
        chk("f_nwrites", wr_addr.size(), ok ? len : 0);
        chk("f_words", 32'(words_loaded), ok ? len : 0);
        chk("f_error", 32'(error), 32'(len > DEPTH));
        chk("f_done", 32'(done), 32'(len <= DEPTH));
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(bus.rx_ready), 0);
        chk("rst_we", 32'(bus.mem_we), 0);
        chk("rst_words", 32'(words_loaded), 0);
        rst_n = 1'b1;
        @(negedge clk);
        frame_a(0, 0);
        wr_addr.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        wait_idle();
        chk("z_done", 32'(done), 1);
        chk("z_words", 32'(words_loaded), 0);
        chk("z_error", 32'(error), 0);
        chk("z_nwrites", wr_addr.size(), 0);
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        wait_idle();
        @(negedge clk);
        chk("e_error", 32'(error), 1);
        chk("e_busy", 32'(busy), 0);
        chk("e_ready", 32'(bus.rx_ready), 0);
        chk("e_nwrites", wr_addr.size(), 0);
        frame_a(0, 0);
        frame_a(5, 0);
        pulse_start();
        send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h13, 0); send_byte(8'h05, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_busy", 32'(busy), 0);
        chk("mr_ready", 32'(bus.rx_ready), 0);
        chk("mr_we", 32'(bus.mem_we), 0);
        chk("mr_addr", bus.mem_addr, 0);
        chk("mr_data", bus.mem_wdata, 0);
        chk("mr_done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame_a(2, 1);
        wr_addr.delete(); wr_data.delete();
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h01;
        pulse_start();
        chk("d_ready", 32'(bus.rx_ready), 1);
        chk("d_done", 32'(done), 0);
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        wait_idle();
        chk("d_nwrites", wr_addr.size(), 1);
        if (wr_addr.size() == 1) begin
            chk("d_addr", wr_addr[0], 32'h0);
            chk("d_data", wr_data[0], 32'h44332211);
        end
        send_frame(DEPTH, 0, 0);
        if (wr_addr.size() > 0) chk("full_last_addr", wr_addr[$], 32'h3FC);
        send_frame(DEPTH + 1, 0, 0);
        for (int it = 0; it < 25; it++) begin
            int r = $urandom_range(0, 7);
            int len = (r == 0) ? 0 : (r == 1) ? DEPTH + 1 + $urandom_range(0, 1000) : $urandom_range(1, 6);
            send_frame(len, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time program loader: the write side of instruction memory. Accepts a little-endian byte stream over a valid/ready handshake (from UART RX or a testbench) and writes whole 32-bit instruction words into instruction memory at consecutive word-aligned byte addresses from 0. Frame is a 16-bit word count followed by count×4 instruction bytes. `busy` holds the CPU in reset while loading.

Parameters:
DEPTH, 256, instruction memory capacity in 32-bit words; counts above this are rejected
ADDR_W, 32, width of mem_addr (byte address, same as PC)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a new load frame
rx_valid  in  1  rx_data holds a byte
rx_data  in  8  stream byte
rx_ready  out  1  loader accepts byte this cycle
mem_we  out  1  instruction memory write strobe, one cycle per word
mem_addr  out  ADDR_W  byte address of write, bits[1:0]=0
mem_wdata  out  32  instruction word
busy  out  1  load in progress (CPU reset hold)
done  out  1  last frame completed successfully (sticky)
error  out  1  last frame rejected, count > DEPTH (sticky)
words_loaded  out  16  words written in current/last frame

Behaviour:
- Reset (async, rst_n=0): state IDLE; rx_ready, mem_we, busy, done, error = 0; mem_addr, mem_wdata, words_loaded = 0; byte buffer and counters cleared. Takes effect immediately mid-frame: no further writes, partial word discarded.
- Byte transfer occurs only on a rising edge with rx_valid && rx_ready. Sender holds rx_data stable while rx_valid=1 and not accepted; loader never drops or duplicates a byte. rx_valid while rx_ready=0 has no effect.
- States:
  IDLE: rx_ready=0. start=1 -> LEN0; busy=1, done=0, error=0, words_loaded=0.
  LEN0: rx_ready=1; accepted byte -> len[7:0]; -> LEN1.
  LEN1: rx_ready=1; accepted byte -> len[15:8]; next: len==0 -> DONE; len>DEPTH -> ERR; else DATA with byte_idx=0, word_idx=0.
  DATA: rx_ready=1; byte k (k=0..3) of word placed in buf[8k+7:8k] (little-endian); after 4th accepted byte -> WRITE.
  WRITE: rx_ready=0; mem_we=1 for exactly this cycle; mem_addr = word_idx×4; mem_wdata = buf; words_loaded = word_idx+1 after the edge; word_idx increments. If word_idx+1 == len -> DONE else -> DATA.
  DONE: busy=0, done=1, rx_ready=0. start=1 -> LEN0 (done clears).
  ERR: busy=0, error=1, rx_ready=0; no mem_we ever issued for this frame. start=1 -> LEN0 (error clears).
- mem_we, rx_ready, busy are registered state decodes (glitch-free); mem_addr/mem_wdata valid whenever mem_we=1, hold last value otherwise.
- Latency: mem_we asserts the cycle after the 4th byte of a word is accepted. Peak throughput 4 bytes per 5 cycles.
- start while busy=1 is ignored (frame continues unchanged). start in same cycle as a byte acceptance in IDLE/DONE/ERR: byte not accepted (rx_ready=0 there).
- len==DEPTH accepted; last write at address (DEPTH-1)×4. Address never wraps: word_idx < len <= DEPTH.
- Stream stalls (rx_valid low any number of cycles) in any state: state held, no timeout.

Test Plan:
- Reset, start, bytes 02 00 13 05 A0 00 93 05 10 00 -> two mem_we pulses: addr 0x0 data 0x00A00513, addr 0x4 data 0x00100593; then done=1, busy=0, words_loaded=2.
- start, bytes 00 00 -> no mem_we; DONE one cycle after second byte; done=1, words_loaded=0, error=0.
- DEPTH=256, start, bytes 01 01 (len=257) -> error=1, busy=0, rx_ready=0, zero mem_we; next start with valid frame clears error and loads.
- Same two-word frame with random rx_valid gaps (0-5 idle cycles) -> identical writes/addresses as stall-free run; each byte consumed exactly once.
- Assert rst_n=0 after 2 data bytes of word 1 -> all outputs 0 immediately; after release, start + full frame writes again from addr 0x0.
- start pulse mid-DATA -> ignored, frame completes normally; start pulse in DONE -> done clears, LEN0 entered, rx_ready=1 next cycle.
